uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the serial-to-display path: samples the board RX pin, deframes 8N1 characters and presents each byte with a single-cycle valid pulse to the seven-segment decoder stage. That stage latches data on the rising edge of `rx_data_valid`, so this block guarantees a clean, registered, one-clock-wide valid pulse, with data already stable when the pulse rises.

## Interface

- `CLK_FREQ`, default 12_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s. `CLK_FREQ/BAUD` must be ≥ 16.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data_valid`  out  1  one-clock pulse per good frame.
- `rx_data_out`  out  8  last good byte, LSB received first.
- `rx_frame_err`  out  1  one-clock pulse when the stop bit is sampled low.

## Operation

- Timing constants: `DIV = CLK_FREQ/BAUD`, integer division (1250 at defaults). `HALF = DIV/2` (625).
- Synchronizer:
  - `rx` passes through 2 flops to give `rx_s`, then 1 delay flop to give `rx_d`.
  - All three flops reset to 1.
  - A start edge is `rx_d==1 && rx_s==0`.
- State machine:
  - **IDLE**: on start edge, clear the baud counter and go to START.
  - **START**: when counter reaches HALF-1, sample `rx_s`.
    - If 0: clear counter, go to DATA.
    - If 1: false start, go to IDLE with no output.
  - **DATA**: each time counter reaches DIV-1, sample `rx_s` into the shift register (right shift, LSB first) and clear the counter. After the 8th bit, go to STOP.
  - **STOP**: when counter reaches DIV-1, sample `rx_s`.
    - If 1: load `rx_data_out` from the shift register and go to IDLE.
    - If 0: pulse `rx_frame_err` and go to BREAK. `rx_data_out` is not updated.
  - **BREAK**: wait until `rx_s==1`, then go to IDLE.
- Valid pulse: `rx_data_valid` is asserted in the cycle after `rx_data_out` loads. It is registered and deasserted the following cycle.
- Baud counter: 0..DIV-1, width `$clog2(DIV)`. Held at 0 in IDLE and BREAK.

## Timing

- Reset values:
  - state IDLE, counter 0, shift register 0.
  - `rx_data_out` = 8'h00, `rx_data_valid` = 0, `rx_frame_err` = 0.
- Reset asserted mid-frame aborts the frame with no valid or error pulse.
- Reset released while the line is low: treated as a start edge. It then resolves through the normal false-start or frame-error paths.
- Latency: let t0 be the first cycle with `rx_s==0`.
  - Bit samples occur at t0+HALF + k·DIV, for k = 0 (start), 1..8 (data), 9 (stop).
  - `rx_data_out` updates at t0+HALF+9·DIV+1, which is t0+11876 at defaults.
  - `rx_data_valid` is high at t0+HALF+9·DIV+2 only.
- `rx_data_out` is stable at least 1 cycle before and throughout the valid pulse, and holds until the next good frame.
- The stop bit is sampled at mid-bit. Back-to-back frames therefore need no extra idle time: a start edge arriving half a bit after the stop sample is caught.
- `rx_frame_err` and `rx_data_valid` are never high in the same cycle.
- Pin change to `rx_s`: 2 cycles.

## Structure

- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - a function `baud_div(clk, baud)`, returning DIV;
  - the 8-bit data width constant.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset-value parameter, reused for other asynchronous pins.
- Everything else stays in one always block for the FSM plus counter, and one for the outputs.

## Test plan

- Reset, then send frame 0x35 ('5') at 9600 baud, 1250 clk/bit → one `rx_data_valid` pulse at t0+11877 (±1); `rx_data_out`=8'h35 one cycle earlier; no `rx_frame_err`.
- Back-to-back "12345678" with zero idle time between frames → 8 valid pulses, 12500 cycles apart; data 0x31..0x38 in order.
- Low glitch of 300 cycles on the idle line → false start, return to IDLE; no valid, no error pulse; a following frame 0xA5 is received correctly.
- Frame 0x55 with the stop bit forced low, line held low 3 bit times → `rx_frame_err` one pulse; `rx_data_out` keeps its previous value; no valid. Next frame 0x0F after the line returns high is received.
- Assert `rst_n` for 10 cycles during data bit 4 of a frame → outputs at reset values; no pulse from the aborted frame; a next clean frame 0x39 is received.
- Baud ±2% skew (1225 and 1275 clk/bit) with frame 0xC3 → received correctly in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   DATA_W    : character width in bits (8N1 framing).
//   ST_*      : receiver state encodings (IDLE, START, DATA, STOP, BREAK).
//   baud_div  : clock cycles per bit, CLK_FREQ/BAUD with integer division.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic int baud_div(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for an asynchronous single-bit input.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, both flops load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output, two clock cycles behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver feeding the seven-segment decoder stage.
//   clk           : system clock, CLK_FREQ Hz
//   rst_n         : asynchronous active-low reset
//   rx            : asynchronous serial line, idle high
//   rx_data_valid : registered one-cycle pulse per good frame, rising one
//                   cycle after rx_data_out has loaded
//   rx_data_out   : last good byte (LSB received first), held until the next
//   rx_frame_err  : one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 9600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              rx_data_valid,
  output logic [DATA_W-1:0] rx_data_out,
  output logic              rx_frame_err
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic              rx_s;
  logic              rx_d;
  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              load_pending;

  // Synchronizer and delay flop all reset to the idle level, so a line that
  // is already low when reset releases still presents a start edge.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_d <= 1'b1;
    else        rx_d <= rx_s;
  end

  wire start_edge  = rx_d & ~rx_s;
  wire stop_sample = (state == ST_STOP) && (cnt == CNT_LAST);

  // Frame sequencing and baud counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (start_edge) state <= ST_START;
        end
        ST_START: begin
          // Mid-point of the start bit: a high line here was only a glitch.
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Sampling mid stop bit leaves half a bit to catch a following
          // back-to-back start edge.
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs: data loads on the stop sample, valid follows a cycle later so the
  // downstream latch sees stable data on the rising edge of the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_out   <= '0;
      load_pending  <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      load_pending  <= stop_sample & rx_s;
      rx_data_valid <= load_pending;
      rx_frame_err  <= stop_sample & ~rx_s;
      if (stop_sample && rx_s) rx_data_out <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at a reduced 50 clk/bit rate.
module tb_uart_rx;

  localparam int CLK_FREQ  = 480_000;
  localparam int BAUD      = 9600;
  localparam int DIV       = CLK_FREQ / BAUD;   // 50
  localparam int HALF      = DIV / 2;           // 25
  localparam int VALID_LAT = HALF + 9 * DIV + 2;
  localparam int ERR_LAT   = HALF + 9 * DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_data_valid;
  logic [7:0] rx_data_out;
  logic       rx_frame_err;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_data_valid (rx_data_valid),
    .rx_data_out   (rx_data_out),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed pulses
  logic [7:0] got_data[$];
  logic [7:0] got_prev[$];
  int         got_vcyc[$];
  int         got_ecyc[$];
  int         overlap = 0;
  int         wide = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Expectations from the reference model
  logic [7:0] exp_data[$];
  int         exp_vcyc[$];
  int         exp_ecyc[$];

  always @(negedge clk) begin
    if (rx_data_valid) begin
      got_data.push_back(rx_data_out);
      got_prev.push_back(prev_data);
      got_vcyc.push_back(cyc);
    end
    if (rx_frame_err) got_ecyc.push_back(cyc);
    if (rx_data_valid && rx_frame_err) overlap <= overlap + 1;
    if ((rx_data_valid && prev_valid) || (rx_frame_err && prev_err)) wide <= wide + 1;
    prev_valid <= rx_data_valid;
    prev_err   <= rx_frame_err;
    prev_data  <= rx_data_out;
  end

  task automatic clear_q();
    got_data.delete(); got_prev.delete(); got_vcyc.delete(); got_ecyc.delete();
    exp_data.delete(); exp_vcyc.delete(); exp_ecyc.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame with p clocks per bit, starting from a high line.
  // The model: rx_s falls two cycles after the pin; a high stop bit yields the
  // byte with valid at t0+HALF+9*DIV+2, a low one an error at one cycle less.
  task automatic drive_frame(input logic [7:0] b, input int p, input logic stop_val);
    int t0;
    t0 = cyc + 2;
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = stop_val;
    repeat (p) @(negedge clk);
    if (stop_val) begin
      exp_data.push_back(b);
      exp_vcyc.push_back(t0 + VALID_LAT);
    end else begin
      exp_ecyc.push_back(t0 + ERR_LAT);
    end
  endtask

  task automatic test_reset();
    clear_q();
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data_out !== 8'h00) begin n_bad++; $display("FAIL reset data: got %h want 00", rx_data_out); end
    n_cmp++; if (rx_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %b want 0", rx_data_valid); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", rx_frame_err); end
    rst_n = 1'b1;
    idle(DIV);
    n_cmp++; if (got_data.size() + got_ecyc.size() != 0) begin n_bad++; $display("FAIL reset quiet: got %0d pulses want 0", got_data.size() + got_ecyc.size()); end
  endtask

  task automatic test_single();
    clear_q();
    drive_frame(8'h35, DIV, 1'b1);
    idle(DIV);
    n_cmp++;
    if (got_data.size() != exp_data.size()) begin
      n_bad++; $display("FAIL single count: got %0d want %0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== exp_data[i] || got_prev[i] !== exp_data[i] || got_vcyc[i] != exp_vcyc[i]) begin
          n_bad++; $display("FAIL single frame%0d: data %h prev %h cyc %0d, want data %h cyc %0d", i, got_data[i], got_prev[i], got_vcyc[i], exp_data[i], exp_vcyc[i]);
        end else $display("single frame %0d: data %h at cycle %0d", i, got_data[i], got_vcyc[i]);
      end
    end
    n_cmp++; if (got_ecyc.size() != 0) begin n_bad++; $display("FAIL single err: got %0d pulses want 0", got_ecyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [8];
    clear_q();
    for (int i = 0; i < 8; i++) s[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 8; i++) drive_frame(s[i], DIV, 1'b1);
    idle(DIV);
    n_cmp++;
    if (got_data.size() != 8) begin
      n_bad++; $display("FAIL b2b count: got %0d want 8", got_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (got_data[i] !== exp_data[i] || got_prev[i] !== exp_data[i] || got_vcyc[i] != exp_vcyc[i]) begin
          n_bad++; $display("FAIL b2b frame%0d: data %h prev %h cyc %0d, want data %h cyc %0d", i, got_data[i], got_prev[i], got_vcyc[i], exp_data[i], exp_vcyc[i]);
        end else $display("b2b frame %0d: data %h at cycle %0d", i, got_data[i], got_vcyc[i]);
      end
      n_cmp++;
      if (got_vcyc[7] - got_vcyc[0] != 7 * 10 * DIV) begin
        n_bad++; $display("FAIL b2b spacing: got %0d want %0d", got_vcyc[7] - got_vcyc[0], 7 * 10 * DIV);
      end
    end
  endtask

  task automatic test_random_frames();
    clear_q();
    for (int i = 0; i < 6; i++) begin
      drive_frame(8'($urandom), DIV, 1'b1);
      idle($urandom_range(0, 2 * DIV));
    end
    idle(DIV);
    n_cmp++;
    if (got_data.size() != exp_data.size()) begin
      n_bad++; $display("FAIL random count: got %0d want %0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== exp_data[i] || got_vcyc[i] != exp_vcyc[i]) begin
          n_bad++; $display("FAIL random frame%0d: data %h cyc %0d, want data %h cyc %0d", i, got_data[i], got_vcyc[i], exp_data[i], exp_vcyc[i]);
        end else $display("random frame %0d: data %h at cycle %0d", i, got_data[i], got_vcyc[i]);
      end
    end
  endtask

  task automatic test_false_start();
    clear_q();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(3 * DIV);
    n_cmp++; if (got_data.size() != 0) begin n_bad++; $display("FAIL glitch valid: got %0d pulses want 0", got_data.size()); end
    n_cmp++; if (got_ecyc.size() != 0) begin n_bad++; $display("FAIL glitch err: got %0d pulses want 0", got_ecyc.size()); end
    drive_frame(8'hA5, DIV, 1'b1);
    idle(DIV);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 8'hA5 || got_vcyc[0] != exp_vcyc[0]) begin
      n_bad++; $display("FAIL glitch next: got %0d pulses data %h want 1 pulse data a5", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
    end else $display("glitch next: data %h at cycle %0d", got_data[0], got_vcyc[0]);
  endtask

  task automatic test_frame_err();
    clear_q();
    drive_frame(8'h55, DIV, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    idle(2 * DIV);
    n_cmp++;
    if (got_ecyc.size() != 1 || got_ecyc[0] != exp_ecyc[0]) begin
      n_bad++; $display("FAIL ferr pulse: got %0d pulses first cyc %0d want 1 at %0d", got_ecyc.size(), (got_ecyc.size() > 0) ? got_ecyc[0] : -1, exp_ecyc[0]);
    end else $display("ferr: error pulse at cycle %0d", got_ecyc[0]);
    n_cmp++; if (got_data.size() != 0) begin n_bad++; $display("FAIL ferr valid: got %0d pulses want 0", got_data.size()); end
    n_cmp++; if (rx_data_out !== 8'hA5) begin n_bad++; $display("FAIL ferr hold: got %h want a5", rx_data_out); end
    drive_frame(8'h0F, DIV, 1'b1);
    idle(DIV);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 8'h0F || got_vcyc[0] != exp_vcyc[0]) begin
      n_bad++; $display("FAIL ferr next: got %0d pulses data %h want 1 pulse data 0f", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
    end else $display("ferr next: data %h at cycle %0d", got_data[0], got_vcyc[0]);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hF3;
    clear_q();
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = b[4];
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_data_out !== 8'h00) begin n_bad++; $display("FAIL midrst data: got %h want 00", rx_data_out); end
    n_cmp++; if (rx_data_valid !== 1'b0 || rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst pulses: got valid %b err %b want 0 0", rx_data_valid, rx_frame_err); end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (DIV - 20) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    idle(2 * DIV);
    n_cmp++; if (got_data.size() + got_ecyc.size() != 0) begin n_bad++; $display("FAIL midrst abort: got %0d pulses want 0", got_data.size() + got_ecyc.size()); end
    drive_frame(8'h39, DIV, 1'b1);
    idle(DIV);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 8'h39 || got_vcyc[0] != exp_vcyc[0]) begin
      n_bad++; $display("FAIL midrst next: got %0d pulses data %h want 1 pulse data 39", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
    end else $display("midrst next: data %h at cycle %0d", got_data[0], got_vcyc[0]);
  endtask

  task automatic test_skew();
    int rates [2];
    rates[0] = DIV - 1;
    rates[1] = DIV + 1;
    for (int r = 0; r < 2; r++) begin
      clear_q();
      drive_frame(8'hC3, rates[r], 1'b1);
      idle(DIV);
      n_cmp++;
      if (got_data.size() != 1 || got_data[0] !== 8'hC3 || got_vcyc[0] != exp_vcyc[0] || got_ecyc.size() != 0) begin
        n_bad++; $display("FAIL skew p=%0d: got %0d pulses data %h errs %0d want 1 pulse data c3", rates[r], got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx, got_ecyc.size());
      end else $display("skew p=%0d: data %h at cycle %0d", rates[r], got_data[0], got_vcyc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_frames();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    test_skew();
    n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL overlap: got %0d cycles with valid and err want 0", overlap); end
    n_cmp++; if (wide != 0) begin n_bad++; $display("FAIL pulse width: got %0d multi-cycle pulses want 0", wide); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
